// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   state_t     : FSM state encoding (IDLE, BUS, RESP)
//   F3_*        : RV32 load/store funct3 encodings accepted by the unit
//   TMO_DEFAULT : default bus-hang watchdog limit, in HLT cycles
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TMO_DEFAULT = 15;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   fn3       in  3 : funct3 of the access
//   ofs       in  2 : byte offset within the word (addr[1:0])
//   wr        in  1 : 1 = store, 0 = load
//   wdata     in 32 : store data from the core (low bits used)
//   rdata     in 32 : word read from the bus
//   be        out 4 : byte enables for the access
//   lane_data out 32: store data replicated across all byte lanes
//   load_data out 32: selected and sign/zero-extended load result
//   illegal   out 1 : bad funct3, unsigned store or misaligned H/W
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  fn3,
  input  logic [1:0]  ofs,
  input  logic        wr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_data,
  output logic [31:0] load_data,
  output logic        illegal
);

  logic [31:0] shifted;

  always_comb begin
    be        = '0;
    lane_data = wdata;
    illegal   = 1'b0;
    case (fn3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << ofs;
        lane_data = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        be        = ofs[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
        illegal   = ofs[0];
      end
      F3_W: begin
        be      = '1;
        illegal = (ofs != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned variants exist only for loads.
    if (wr && (fn3 == F3_BU || fn3 == F3_HU)) illegal = 1'b1;
  end

  assign shifted = rdata >> {ofs, 3'b000};

  always_comb begin
    case (fn3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding RV32 load/store initiator on the
// unified memory data port.
//   CLK, RES            : clock (rising edge), async active-high reset
//   REQ_VLD/REQ_RDY     : core request handshake
//   REQ_WR, REQ_FN3     : store flag and RV32 funct3
//   REQ_ADDR, REQ_DATA  : byte address and store data
//   RSP_VLD             : one-cycle response pulse
//   RSP_DATA, RSP_ERR   : registered load result / error flag
//   DADDR, DATAO, DATAI : word-aligned bus address, write data, read data
//   WR, RD, BE          : bus strobes and byte enables (active in BUS only)
//   HLT                 : memory wait request
// TMO sets how many consecutive HLT cycles are tolerated before abort.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEFAULT
)
(
  input  logic        CLK,
  input  logic        RES,
  input  logic        REQ_VLD,
  output logic        REQ_RDY,
  input  logic        REQ_WR,
  input  logic [2:0]  REQ_FN3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_DATA,
  output logic        RSP_VLD,
  output logic [31:0] RSP_DATA,
  output logic        RSP_ERR,
  output logic [31:0] DADDR,
  output logic [31:0] DATAO,
  input  logic [31:0] DATAI,
  output logic        WR,
  output logic        RD,
  output logic [3:0]  BE,
  input  logic        HLT
);

  localparam logic [3:0] WDOG_LAST = 4'(TMO - 1);

  state_t      state;
  logic        up;
  logic [2:0]  fn3_q;
  logic [1:0]  ofs_q;
  logic        wr_q;
  logic [3:0]  wdog;

  logic        idle;
  logic        in_bus;
  logic        xfer;
  logic [2:0]  a_fn3;
  logic [1:0]  a_ofs;
  logic        a_wr;
  logic [3:0]  a_be;
  logic [31:0] a_lane;
  logic [31:0] a_load;
  logic        a_illegal;

  assign idle   = (state == IDLE);
  assign in_bus = (state == BUS);

  // One aligner serves both phases: in IDLE it classifies the incoming
  // request, afterwards it works from the latched fields.
  assign a_fn3 = idle ? REQ_FN3       : fn3_q;
  assign a_ofs = idle ? REQ_ADDR[1:0] : ofs_q;
  assign a_wr  = idle ? REQ_WR        : wr_q;

  lsu_align u_align (
    .fn3       (a_fn3),
    .ofs       (a_ofs),
    .wr        (a_wr),
    .wdata     (REQ_DATA),
    .rdata     (DATAI),
    .be        (a_be),
    .lane_data (a_lane),
    .load_data (a_load),
    .illegal   (a_illegal)
  );

  // 'up' keeps REQ_RDY low while reset is held without using RES as data.
  assign REQ_RDY = idle && up;
  assign xfer    = REQ_VLD && REQ_RDY;
  assign RSP_VLD = (state == RESP);

  // Strobes decode from state so an async reset drops them immediately.
  assign RD = in_bus && !wr_q;
  assign WR = in_bus && wr_q;
  assign BE = in_bus ? a_be : '0;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state    <= IDLE;
      up       <= 1'b0;
      fn3_q    <= '0;
      ofs_q    <= '0;
      wr_q     <= 1'b0;
      wdog     <= '0;
      DADDR    <= '0;
      DATAO    <= '0;
      RSP_DATA <= '0;
      RSP_ERR  <= 1'b0;
    end else begin
      up <= 1'b1;
      case (state)
        IDLE: begin
          if (xfer) begin
            if (a_illegal) begin
              RSP_ERR  <= 1'b1;
              RSP_DATA <= '0;
              state    <= RESP;
            end else begin
              fn3_q <= REQ_FN3;
              ofs_q <= REQ_ADDR[1:0];
              wr_q  <= REQ_WR;
              wdog  <= '0;
              DADDR <= {REQ_ADDR[31:2], 2'b00};
              if (REQ_WR) DATAO <= a_lane;
              state <= BUS;
            end
          end
        end
        BUS: begin
          if (!HLT) begin
            RSP_ERR  <= 1'b0;
            RSP_DATA <= wr_q ? '0 : a_load;
            state    <= RESP;
          end else if (wdog == WDOG_LAST) begin
            RSP_ERR  <= 1'b1;
            RSP_DATA <= '0;
            state    <= RESP;
          end else begin
            wdog <= wdog + 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed cases with literal expectations, then
// randomized requests checked every cycle against a behavioural model.
module tb_lsu;
  import lsu_pkg::*;

  localparam int TMO = 15;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic        REQ_VLD = 1'b0;
  logic        REQ_RDY;
  logic        REQ_WR = 1'b0;
  logic [2:0]  REQ_FN3 = '0;
  logic [31:0] REQ_ADDR = '0;
  logic [31:0] REQ_DATA = '0;
  logic        RSP_VLD;
  logic [31:0] RSP_DATA;
  logic        RSP_ERR;
  logic [31:0] DADDR;
  logic [31:0] DATAO;
  logic [31:0] DATAI;
  logic        WR;
  logic        RD;
  logic [3:0]  BE;
  logic        HLT = 1'b0;

  lsu #(.TMO(TMO)) dut (
    .CLK(CLK), .RES(RES),
    .REQ_VLD(REQ_VLD), .REQ_RDY(REQ_RDY), .REQ_WR(REQ_WR), .REQ_FN3(REQ_FN3),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .RSP_VLD(RSP_VLD), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .DADDR(DADDR), .DATAO(DATAO), .DATAI(DATAI),
    .WR(WR), .RD(RD), .BE(BE), .HLT(HLT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_illegal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return a[0];
      3'b010:  return a[1:0] != 2'b00;
      3'b100:  return wr;
      3'b101:  return wr || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] mask;
    mask = 4'((1 << nbytes(f3)) - 1);
    return mask << a[1:0];
  endfunction

  function automatic logic [31:0] m_lane(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v;
    logic [31:0] mask;
    int n;
    n = nbytes(f3);
    v = w >> (8 * a[1:0]);
    if (n == 4) return v;
    mask = (32'h1 << (8 * n)) - 32'h1;
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- bus memory (drives HLT / DATAI) ----------------
  logic [31:0] bus_mem [64];
  logic [31:0] ref_mem [64];
  int          hlt_waits = 0;  // -1: memory default (load 1 wait, store 0)

  assign DATAI = HLT ? 32'hBAD0_BAD0 : bus_mem[DADDR[7:2]];

  initial begin
    for (int i = 0; i < 64; i++) bus_mem[i] = $urandom;
    forever begin
      @(posedge CLK);
      if (WR && !HLT && !RES)
        for (int i = 0; i < 4; i++)
          if (BE[i]) bus_mem[DADDR[7:2]][8*i +: 8] = DATAO[8*i +: 8];
    end
  end

  initial begin
    int  wl;
    bit  acc;
    wl = 0;
    acc = 1'b0;
    forever begin
      @(negedge CLK);
      if (RD || WR) begin
        if (!acc) begin
          acc = 1'b1;
          wl = (hlt_waits < 0) ? (RD ? 1 : 0) : hlt_waits;
        end
        HLT = (wl > 0);
        if (wl > 0) wl--;
      end else begin
        acc = 1'b0;
        HLT = 1'b0;
      end
    end
  end

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  int          due = -1;
  int          hold = 0;
  bit          busy, in_bus, m_up, m_wr, m_rsp_err;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_data, m_daddr, m_datao, m_rsp_data;

  task automatic reset_model();
    busy = 1'b0; in_bus = 1'b0; m_up = 1'b0; hold = 0; due = -1;
    m_daddr = '0; m_datao = '0; m_rsp_data = '0; m_rsp_err = 1'b0;
  endtask

  initial begin
    logic [3:0]  be;
    logic [31:0] ln;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    #0;
    for (int i = 0; i < 64; i++) ref_mem[i] = bus_mem[i];
    reset_model();
    forever begin
      @(posedge CLK or posedge RES);
      if (RES) reset_model();
      else begin
        if (busy && !in_bus && cyc == due) begin
          busy = 1'b0;
        end else if (in_bus) begin
          if (!HLT) begin
            if (m_wr) begin
              be = m_be(m_f3, m_addr);
              ln = m_lane(m_f3, m_data);
              for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[m_addr[7:2]][8*i +: 8] = ln[8*i +: 8];
              m_rsp_data = '0;
            end else begin
              m_rsp_data = m_load(m_f3, m_addr, ref_mem[m_addr[7:2]]);
            end
            m_rsp_err = 1'b0;
            in_bus = 1'b0;
            due = cyc + 1;
          end else if (hold + 1 == TMO) begin
            m_rsp_err = 1'b1;
            m_rsp_data = '0;
            in_bus = 1'b0;
            due = cyc + 1;
          end else begin
            hold++;
          end
        end else if (!busy && m_up && REQ_VLD) begin
          busy = 1'b1;
          if (m_illegal(REQ_WR, REQ_FN3, REQ_ADDR)) begin
            m_rsp_err = 1'b1;
            m_rsp_data = '0;
            due = cyc + 1;
          end else begin
            in_bus = 1'b1;
            hold = 0;
            m_wr = REQ_WR;
            m_f3 = REQ_FN3;
            m_addr = REQ_ADDR;
            m_data = REQ_DATA;
            m_daddr = {REQ_ADDR[31:2], 2'b00};
            if (REQ_WR) m_datao = m_lane(REQ_FN3, REQ_DATA);
          end
        end
        m_up = 1'b1;
        cyc++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      chk("req_rdy",  32'(REQ_RDY),  32'(!busy && m_up));
      chk("rsp_vld",  32'(RSP_VLD),  32'(busy && !in_bus && cyc == due));
      chk("rsp_data", RSP_DATA,      m_rsp_data);
      chk("rsp_err",  32'(RSP_ERR),  32'(m_rsp_err));
      chk("rd",       32'(RD),       32'(in_bus && !m_wr));
      chk("wr",       32'(WR),       32'(in_bus && m_wr));
      chk("be",       32'(BE),       32'(in_bus ? m_be(m_f3, m_addr) : 4'b0000));
      chk("daddr",    DADDR,         m_daddr);
      if (in_bus && m_wr) chk("datao", DATAO, m_datao);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int waits,
                        output logic [31:0] rdata, output logic rerr, output int lat,
                        output int strobes, output logic [3:0] be1,
                        output logic [31:0] daddr1, output logic [31:0] dout1);
    int n;
    rdata = '0; rerr = 1'b0; lat = 0; strobes = 0;
    be1 = '0; daddr1 = '0; dout1 = '0;
    hlt_waits = waits;
    REQ_VLD = 1'b1; REQ_WR = wr; REQ_FN3 = f3; REQ_ADDR = a; REQ_DATA = d;
    n = 0;
    while (!REQ_RDY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!REQ_RDY) begin
      chk("accept_wait", 32'(REQ_RDY), 32'd1);
      REQ_VLD = 1'b0;
      return;
    end
    @(negedge CLK);
    REQ_VLD = 1'b0;
    REQ_WR = 1'($urandom); REQ_FN3 = 3'($urandom);
    REQ_ADDR = $urandom; REQ_DATA = $urandom;
    be1 = BE; daddr1 = DADDR; dout1 = DATAO;
    lat = 1;
    while (!RSP_VLD && lat < 40) begin
      if (RD || WR) strobes++;
      @(negedge CLK);
      lat++;
    end
    if (!RSP_VLD) chk("rsp_wait", 32'(RSP_VLD), 32'd1);
    rdata = RSP_DATA;
    rerr = RSP_ERR;
  endtask

  initial begin
    logic [31:0] rd_d, a1, d1, ad;
    logic        re, w;
    logic [3:0]  b1;
    logic [2:0]  f3;
    int          lat, st, n, r, waits;
    logic [2:0]  legal [5];
    legal = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

    #1 RES = 1'b1;
    repeat (3) @(negedge CLK);
    chk("reset_rdy",  32'(REQ_RDY), 32'd0);
    chk("reset_rsp",  32'(RSP_VLD), 32'd0);
    chk("reset_strb", 32'({RD, WR, BE}), 32'd0);
    chk("reset_addr", DADDR, 32'd0);
    RES = 1'b0;
    @(negedge CLK);

    // SW 0x100
    do_req(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0, rd_d, re, lat, st, b1, a1, d1);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", 32'(re), 32'd0);
    chk("sw_be", 32'(b1), 32'hF);
    chk("sw_daddr", a1, 32'h100);
    chk("sw_dout", d1, 32'hDEADBEEF);
    chk("sw_strobes", 32'(st), 32'd1);
    // SB 0x103
    do_req(1'b1, F3_B, 32'h103, 32'h1234565A, 0, rd_d, re, lat, st, b1, a1, d1);
    chk("sb_be", 32'(b1), 32'h8);
    chk("sb_dout", d1, 32'h5A5A5A5A);
    // LW 0x100 via memory
    do_req(1'b0, F3_W, 32'h100, 32'h0, -1, rd_d, re, lat, st, b1, a1, d1);
    chk("lw_data", rd_d, 32'h5AADBEEF);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_strobes", 32'(st), 32'd2);
    // LB / LBU 0x102 on word 0x12F03456
    do_req(1'b1, F3_W, 32'h100, 32'h12F03456, 0, rd_d, re, lat, st, b1, a1, d1);
    do_req(1'b0, F3_B, 32'h102, 32'h0, -1, rd_d, re, lat, st, b1, a1, d1);
    chk("lb_data", rd_d, 32'hFFFFFFF0);
    chk("lb_lat", 32'(lat), 32'd3);
    chk("lb_be", 32'(b1), 32'h4);
    do_req(1'b0, F3_BU, 32'h102, 32'h0, -1, rd_d, re, lat, st, b1, a1, d1);
    chk("lbu_data", rd_d, 32'h000000F0);
    // Illegal requests
    do_req(1'b0, F3_H, 32'h101, 32'h0, 0, rd_d, re, lat, st, b1, a1, d1);
    chk("lh_mis_err", 32'(re), 32'd1);
    chk("lh_mis_lat", 32'(lat), 32'd1);
    chk("lh_mis_strb", 32'(st), 32'd0);
    do_req(1'b1, F3_W, 32'h102, 32'h0, 0, rd_d, re, lat, st, b1, a1, d1);
    chk("sw_mis_err", 32'(re), 32'd1);
    chk("sw_mis_lat", 32'(lat), 32'd1);
    chk("sw_mis_dout", DATAO, 32'h12F03456);
    do_req(1'b0, 3'b011, 32'h100, 32'h0, 0, rd_d, re, lat, st, b1, a1, d1);
    chk("f3_011_err", 32'(re), 32'd1);
    chk("f3_011_lat", 32'(lat), 32'd1);
    do_req(1'b1, F3_BU, 32'h100, 32'h0, 0, rd_d, re, lat, st, b1, a1, d1);
    chk("sbu_err", 32'(re), 32'd1);
    chk("sbu_data", rd_d, 32'h0);
    chk("sbu_strb", 32'(st), 32'd0);
    // Watchdog
    do_req(1'b0, F3_W, 32'h100, 32'h0, 99, rd_d, re, lat, st, b1, a1, d1);
    chk("tmo_err", 32'(re), 32'd1);
    chk("tmo_lat", 32'(lat), 32'd16);
    chk("tmo_strobes", 32'(st), 32'd15);
    chk("tmo_data", rd_d, 32'h0);

    // Reset pulse during a BUS-state load
    hlt_waits = 99;
    REQ_VLD = 1'b1; REQ_WR = 1'b0; REQ_FN3 = F3_W; REQ_ADDR = 32'h100;
    n = 0;
    while (!REQ_RDY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_accept", 32'(REQ_RDY), 32'd1);
    @(negedge CLK);
    REQ_VLD = 1'b0;
    @(negedge CLK);
    chk("rst_rd_before", 32'(RD), 32'd1);
    #2 RES = 1'b1;
    #1;
    chk("rst_async_strb", 32'({RD, WR, BE}), 32'd0);
    chk("rst_async_daddr", DADDR, 32'd0);
    chk("rst_async_dout", DATAO, 32'd0);
    chk("rst_async_rsp", 32'({RSP_VLD, RSP_ERR}), 32'd0);
    chk("rst_async_rdy", 32'(REQ_RDY), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RES = 1'b0;
    @(negedge CLK);
    chk("rst_rdy_after", 32'(REQ_RDY), 32'd1);
    chk("rst_no_rsp", 32'(RSP_VLD), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = legal[$urandom_range(0, 4)];
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
      r = int'($urandom_range(0, 19));
      if (r == 0) waits = 99;
      else if (r < 6) waits = -1;
      else waits = int'($urandom_range(0, 3));
      do_req(w, f3, ad, $urandom, waits, rd_d, re, lat, st, b1, a1, d1);
    end
    repeat (3) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "global timeout");
  end

endmodule
